// File: rtl/rv32m_issue_ctrl_pkg.sv
// Shared definitions for the RV32M issue/sequencing stage: funct3 codes,
// FSM state encoding and the special operand/result constants.
package rv32m_issue_ctrl_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL1    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic is_divrem(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/rv32m_issue_ctrl_fastpath.sv
// Combinational corner-case resolver: decides whether an M-op can be
// answered without the iterative unit and, if so, what the result is.
module rv32m_issue_ctrl_fastpath
  import rv32m_issue_ctrl_pkg::*;
#(
  parameter bit FAST_PATH = 1'b1
) (
  input  logic [2:0]  funct3_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        hit_o,
  output logic [31:0] result_o
);

  logic is_div;
  logic is_signed_divrem;

  assign is_div           = (funct3_i == F3_DIV) || (funct3_i == F3_DIVU);
  assign is_signed_divrem = (funct3_i == F3_DIV) || (funct3_i == F3_REM);

  // Priority: divide-by-zero, then signed overflow, then optional mul-by-zero.
  always_comb begin
    hit_o    = 1'b0;
    result_o = 32'h0;
    if (is_divrem(funct3_i) && (b_i == 32'h0)) begin
      hit_o    = 1'b1;
      result_o = is_div ? ALL1 : a_i;
    end else if (is_signed_divrem && (a_i == INT_MIN) && (b_i == ALL1)) begin
      hit_o    = 1'b1;
      result_o = (funct3_i == F3_DIV) ? INT_MIN : 32'h0;
    end else if (FAST_PATH && !is_divrem(funct3_i) && ((a_i == 32'h0) || (b_i == 32'h0))) begin
      hit_o    = 1'b1;
      result_o = 32'h0;
    end
  end

endmodule

// File: rtl/rv32m_issue_ctrl.sv
// Issue stage in front of the iterative RV32M mul/div unit: accepts one
// request, resolves corner cases and repeats locally, otherwise starts the
// unit, captures its first result and holds it until writeback accepts.
module rv32m_issue_ctrl
  import rv32m_issue_ctrl_pkg::*;
#(
  parameter bit FAST_PATH = 1'b1,
  parameter bit CACHE_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  input  logic        kill,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        busy,
  output logic        mdu_start,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  output logic [2:0]  mdu_m,
  input  logic        mdu_finish,
  input  logic [31:0] mdu_r
);

  state_e      state_q, state_d;
  logic [31:0] op_a_q, op_b_q, resp_data_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;

  logic        cache_valid_q;
  logic [2:0]  cache_f3_q;
  logic [31:0] cache_a_q, cache_b_q, cache_r_q;

  logic        fp_hit;
  logic [31:0] fp_result;
  logic        cache_hit;
  logic        accept;
  logic        capture;
  logic        retire;

  rv32m_issue_ctrl_fastpath #(.FAST_PATH(FAST_PATH)) u_fastpath (
    .funct3_i (req_funct3),
    .a_i      (req_a),
    .b_i      (req_b),
    .hit_o    (fp_hit),
    .result_o (fp_result)
  );

  assign cache_hit = CACHE_EN && cache_valid_q && (cache_f3_q == req_funct3) &&
                     (cache_a_q == req_a) && (cache_b_q == req_b);

  assign req_ready  = (state_q == IDLE) && !kill;
  assign accept     = req_valid && req_ready;
  // The unit's result is sampled only on the WAIT->RESP edge; later changes on mdu_r are ignored.
  assign capture    = (state_q == WAIT) && !kill && mdu_finish;
  assign retire     = (state_q == RESP) && !kill && resp_ready;

  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign mdu_start  = (state_q == ISSUE);
  assign resp_data  = resp_data_q;
  assign resp_rd    = rd_q;
  assign mdu_a      = op_a_q;
  assign mdu_b      = op_b_q;
  assign mdu_m      = funct3_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; kill overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = (fp_hit || cache_hit) ? RESP : ISSUE;
      ISSUE: state_d = kill ? IDLE : WAIT;
      WAIT:  if (kill) state_d = IDLE;
             else if (mdu_finish) state_d = RESP;
      RESP:  if (kill || resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/tag latch on acceptance and result capture from either source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q      <= 32'h0;
      op_b_q      <= 32'h0;
      funct3_q    <= 3'h0;
      rd_q        <= 5'h0;
      resp_data_q <= 32'h0;
    end else if (accept) begin
      op_a_q   <= req_a;
      op_b_q   <= req_b;
      funct3_q <= req_funct3;
      rd_q     <= req_rd;
      if (fp_hit)         resp_data_q <= fp_result;
      else if (cache_hit) resp_data_q <= cache_r_q;
    end else if (capture) begin
      resp_data_q <= mdu_r;
    end
  end

  // One-entry repeat cache, refreshed on every completed handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid_q <= 1'b0;
      cache_f3_q    <= 3'h0;
      cache_a_q     <= 32'h0;
      cache_b_q     <= 32'h0;
      cache_r_q     <= 32'h0;
    end else if (retire && CACHE_EN) begin
      cache_valid_q <= 1'b1;
      cache_f3_q    <= funct3_q;
      cache_a_q     <= op_a_q;
      cache_b_q     <= op_b_q;
      cache_r_q     <= resp_data_q;
    end
  end

endmodule

// File: tb/tb_rv32m_issue_ctrl.sv
// Self-checking bench for rv32m_issue_ctrl: a transaction-level model of the
// expected behaviour, an emulated iterative unit, and directed scenarios.
module tb_rv32m_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'h0;
  logic [31:0] req_a = 32'h0;
  logic [31:0] req_b = 32'h0;
  logic [4:0]  req_rd = 5'h0;
  logic        kill = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        busy;
  logic        mdu_start;
  logic [31:0] mdu_a, mdu_b;
  logic [2:0]  mdu_m;
  logic        mdu_finish;
  logic [31:0] mdu_r;

  int vectors = 0;
  int miscompares = 0;
  int starts = 0;

  always #5 clk = ~clk;

  rv32m_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .busy(busy), .mdu_start(mdu_start), .mdu_a(mdu_a),
    .mdu_b(mdu_b), .mdu_m(mdu_m), .mdu_finish(mdu_finish), .mdu_r(mdu_r)
  );

  // Architectural RV32M result, straight from the ISA definition.
  function automatic logic [31:0] golden(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            else return 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            else return 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Ops that never need the unit (FAST_PATH=1).
  function automatic logic is_corner(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1'b1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1'b1;
    if (!f[2] && (a == 0 || b == 0)) return 1'b1;
    return 1'b0;
  endfunction

  // Emulated unit: finish 34 cycles after the start cycle (66 for mulh),
  // result valid only in the first finish cycle, then overwritten.
  int          u_cnt = 0;
  int          u_lat = 0;
  logic        u_act = 1'b0;
  logic [31:0] u_res = 32'h0;
  always @(posedge clk) begin
    if (mdu_start) begin
      u_act <= 1'b1;
      u_cnt <= 0;
      u_lat <= (mdu_m == 3'd1) ? 65 : 33;
      u_res <= golden(mdu_m, mdu_a, mdu_b);
      starts <= starts + 1;
    end else if (u_act) begin
      u_cnt <= u_cnt + 1;
    end
  end
  assign mdu_finish = u_act && (u_cnt >= u_lat);
  assign mdu_r      = (u_cnt == u_lat) ? u_res : (u_res ^ 32'h5A5A0001);

  // Transaction model: 0 idle, 1 unit op in flight, 2 result presented.
  int          m_state = 0;
  int          m_cnt = 0;
  int          m_lat = 0;
  logic [2:0]  m_f = 3'h0;
  logic [31:0] m_a = 32'h0, m_b = 32'h0, m_res = 32'h0;
  logic [4:0]  m_rd = 5'h0;
  logic        c_v = 1'b0;
  logic [2:0]  c_f = 3'h0;
  logic [31:0] c_a = 32'h0, c_b = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      c_v     <= 1'b0;
    end else begin
      case (m_state)
        0: if (req_valid && !kill) begin
             m_f   <= req_funct3;
             m_a   <= req_a;
             m_b   <= req_b;
             m_rd  <= req_rd;
             m_res <= golden(req_funct3, req_a, req_b);
             m_cnt <= 1;
             if (is_corner(req_funct3, req_a, req_b) ||
                 (c_v && c_f == req_funct3 && c_a == req_a && c_b == req_b)) begin
               m_state <= 2;
             end else begin
               m_state <= 1;
               m_lat   <= (req_funct3 == 3'd1) ? 68 : 36;
             end
           end
        1: if (kill) m_state <= 0;
           else begin
             if (m_cnt + 1 == m_lat) m_state <= 2;
             m_cnt <= m_cnt + 1;
           end
        default: if (kill) m_state <= 0;
                 else if (resp_ready) begin
                   m_state <= 0;
                   c_v <= 1'b1;
                   c_f <= m_f;
                   c_a <= m_a;
                   c_b <= m_b;
                 end
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    check("resp_valid", 32'(resp_valid), 32'(m_state == 2));
    check("busy", 32'(busy), 32'(m_state != 0));
    check("req_ready", 32'(req_ready), 32'(m_state == 0 && !kill));
    check("mdu_start", 32'(mdu_start), 32'(m_state == 1 && m_cnt == 1));
    if (m_state == 2) begin
      check("resp_data", resp_data, m_res);
      check("resp_rd", 32'(resp_rd), 32'(m_rd));
    end
    if (m_state == 1) begin
      check("mdu_a", mdu_a, m_a);
      check("mdu_b", mdu_b, m_b);
      check("mdu_m", 32'(mdu_m), 32'(m_f));
    end
  end

  task automatic reset_vals(input string nm);
    check({nm, " resp_valid"}, 32'(resp_valid), 32'h0);
    check({nm, " resp_data"}, resp_data, 32'h0);
    check({nm, " resp_rd"}, 32'(resp_rd), 32'h0);
    check({nm, " mdu_start"}, 32'(mdu_start), 32'h0);
    check({nm, " mdu_a"}, mdu_a, 32'h0);
    check({nm, " mdu_b"}, mdu_b, 32'h0);
    check({nm, " mdu_m"}, 32'(mdu_m), 32'h0);
    check({nm, " busy"}, 32'(busy), 32'h0);
  endtask

  // Called at posedge+1 with the DUT idle; issues one op and retires it.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int hold,
                        input logic [31:0] exp_data, input int exp_lat, input int exp_starts);
    int          cyc;
    int          s0;
    logic [31:0] held;
    s0 = starts;
    req_valid = 1'b1; req_funct3 = f; req_a = a; req_b = b; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, " latency"}, 32'(cyc), 32'(exp_lat));
    check({nm, " data"}, resp_data, exp_data);
    check({nm, " rd"}, 32'(resp_rd), 32'(rd));
    held = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, " held data"}, resp_data, held);
      check({nm, " held req_ready"}, 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({nm, " idle after ready"}, 32'(busy), 32'h0);
    check({nm, " start pulses"}, 32'(starts - s0), 32'(exp_starts));
    $display("%s: f3=%0d a=%h b=%h -> %h latency %0d", nm, f, a, b, resp_data_seen(held), cyc);
  endtask

  function automatic logic [31:0] resp_data_seen(input logic [31:0] v);
    return v;
  endfunction

  initial begin
    int cyc;
    int seen;
    repeat (3) @(posedge clk);
    #1;
    reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unit path and repeat cache.
    run_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 0, 32'hFFFFFFEB, 36, 1);
    run_op("mulh min*min", 3'd1, 32'h80000000, 32'h80000000, 5'd2, 0, 32'h40000000, 68, 1);
    run_op("mulh repeat", 3'd1, 32'h80000000, 32'h80000000, 5'd3, 0, 32'h40000000, 1, 0);

    // Corner cases resolved without the unit.
    run_op("divu by 0", 3'd5, 32'd5, 32'd0, 5'd4, 0, 32'hFFFFFFFF, 1, 0);
    run_op("rem by 0", 3'd6, 32'd5, 32'd0, 5'd5, 0, 32'd5, 1, 0);
    run_op("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd6, 0, 32'h80000000, 1, 0);
    run_op("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd7, 0, 32'h0, 1, 0);
    run_op("mulhu by 0", 3'd3, 32'h0, 32'h12345678, 5'd8, 0, 32'h0, 1, 0);
    run_op("mulhsu -1*max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 0, 32'hFFFFFFFF, 36, 1);

    // Backpressure.
    run_op("div -7/2 bp", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd10, 10, 32'hFFFFFFFD, 36, 1);

    // Kill in WAIT at cycle 20.
    req_valid = 1'b1; req_funct3 = 3'd5; req_a = 32'd100; req_b = 32'd7; req_rd = 5'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    seen = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (resp_valid) seen++;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill idle at 21", 32'(busy), 32'h0);
    check("kill no resp", 32'(seen + int'(resp_valid)), 32'h0);
    $display("kill: divu 100/7 abandoned at cycle 20");
    run_op("remu after kill", 3'd7, 32'd100, 32'd7, 5'd12, 0, 32'd2, 36, 1);

    // kill together with req_valid in IDLE: not accepted.
    req_valid = 1'b1; kill = 1'b1; req_funct3 = 3'd4; req_a = 32'd9; req_b = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0; kill = 1'b0;
    check("kill blocks accept", 32'(busy), 32'h0);
    $display("kill in idle: request not accepted");

    // Reset in the middle of WAIT.
    req_valid = 1'b1; req_funct3 = 3'd0; req_a = 32'd5; req_b = 32'd6; req_rd = 5'd13;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    reset_vals("mid-op reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    check("stale finish ignored", 32'(busy), 32'h0);
    $display("reset during WAIT: outputs cleared, stale finish ignored");
    run_op("mul 3*4 after reset", 3'd0, 32'd3, 32'd4, 5'd14, 0, 32'd12, 36, 1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
